// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, functs,
// ALU operation encodings and the controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder: maps the funct field to an ALU operation and flags
// whether the funct is one the core implements.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_Funct,
    output logic [2:0] o_ALUControl,
    output logic       o_funct_valid
);

    always_comb begin
        o_ALUControl  = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_Funct)
            FN_ADD:  o_ALUControl = ALU_ADD;
            FN_SUB:  o_ALUControl = ALU_SUB;
            FN_AND:  o_ALUControl = ALU_AND;
            FN_OR:   o_ALUControl = ALU_OR;
            FN_SLT:  o_ALUControl = ALU_SLT;
            default: o_funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback steps, driving every datapath enable and mux select.
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_Op,
    input  logic [5:0] i_Funct,
    input  logic       i_zero_flag,
    input  logic       i_MemReady,
    output logic       o_IorD,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_PCEn,
    output logic [1:0] o_PCSrc,
    output logic       o_RegDst,
    output logic       o_MemtoReg,
    output logic       o_RegWrite,
    output logic       o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [2:0] o_ALUControl
);

    state_e     state_q, state_d;
    logic [2:0] dec_alu;
    logic       dec_valid;

    mips_alu_decoder u_alu_dec (
        .i_Funct       (i_Funct),
        .o_ALUControl  (dec_alu),
        .o_funct_valid (dec_valid)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (i_MemReady) state_d = ST_DECODE;
            ST_DECODE: begin
                case (i_Op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEXEC;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:   state_d = (i_Op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  if (i_MemReady) state_d = ST_MEMWB;
            ST_MEMWRITE: if (i_MemReady) state_d = ST_FETCH;
            ST_EXECUTE:  state_d = dec_valid ? ST_ALUWB : ST_FETCH;
            ST_ADDIEXEC: state_d = ST_ADDIWB;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Reset gates every output so a strobe cannot fire mid-instruction.
    always_comb begin
        o_IorD       = 1'b0;
        o_MemWrite   = 1'b0;
        o_IRWrite    = 1'b0;
        o_PCEn       = 1'b0;
        o_PCSrc      = 2'b00;
        o_RegDst     = 1'b0;
        o_MemtoReg   = 1'b0;
        o_RegWrite   = 1'b0;
        o_ALUSrcA    = 1'b0;
        o_ALUSrcB    = 2'b00;
        o_ALUControl = ALU_ADD;
        if (!i_rst) begin
            case (state_q)
                ST_FETCH: begin
                    o_ALUSrcB = 2'b01;
                    o_IRWrite = i_MemReady;
                    o_PCEn    = i_MemReady;
                end
                ST_DECODE:   o_ALUSrcB = 2'b11;
                ST_MEMADR: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUSrcB = 2'b10;
                end
                ST_MEMREAD:  o_IorD = 1'b1;
                ST_MEMWB: begin
                    o_MemtoReg = 1'b1;
                    o_RegWrite = 1'b1;
                end
                ST_MEMWRITE: begin
                    o_IorD     = 1'b1;
                    o_MemWrite = 1'b1;
                end
                ST_EXECUTE: begin
                    o_ALUSrcA    = 1'b1;
                    o_ALUControl = dec_alu;
                end
                ST_ALUWB: begin
                    o_RegDst   = 1'b1;
                    o_RegWrite = 1'b1;
                end
                ST_BRANCH: begin
                    o_ALUSrcA    = 1'b1;
                    o_ALUControl = ALU_SUB;
                    o_PCSrc      = 2'b01;
                    o_PCEn       = i_zero_flag;
                end
                ST_ADDIEXEC: begin
                    o_ALUSrcA = 1'b1;
                    o_ALUSrcB = 2'b10;
                end
                ST_ADDIWB:   o_RegWrite = 1'b1;
                ST_JUMP: begin
                    o_PCSrc = 2'b10;
                    o_PCEn  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for the multicycle controller: walks each instruction class
// cycle by cycle and compares the packed control word against fixed values.
module tb_mips_mc_controller;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [5:0] i_Op = 6'd0;
    logic [5:0] i_Funct = 6'd0;
    logic       i_zero_flag = 1'b0;
    logic       i_MemReady = 1'b1;
    logic       o_IorD, o_MemWrite, o_IRWrite, o_PCEn;
    logic [1:0] o_PCSrc;
    logic       o_RegDst, o_MemtoReg, o_RegWrite, o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [2:0] o_ALUControl;

    int n_tests = 0;
    int n_fail  = 0;

    mips_mc_controller dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_Op         (i_Op),
        .i_Funct      (i_Funct),
        .i_zero_flag  (i_zero_flag),
        .i_MemReady   (i_MemReady),
        .o_IorD       (o_IorD),
        .o_MemWrite   (o_MemWrite),
        .o_IRWrite    (o_IRWrite),
        .o_PCEn       (o_PCEn),
        .o_PCSrc      (o_PCSrc),
        .o_RegDst     (o_RegDst),
        .o_MemtoReg   (o_MemtoReg),
        .o_RegWrite   (o_RegWrite),
        .o_ALUSrcA    (o_ALUSrcA),
        .o_ALUSrcB    (o_ALUSrcB),
        .o_ALUControl (o_ALUControl)
    );

    always #5 i_clk = ~i_clk;

    // Packed as {IorD,MemWrite,IRWrite,PCEn,PCSrc,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl}
    logic [14:0] obs;
    assign obs = {o_IorD, o_MemWrite, o_IRWrite, o_PCEn, o_PCSrc, o_RegDst,
                  o_MemtoReg, o_RegWrite, o_ALUSrcA, o_ALUSrcB, o_ALUControl};

    function automatic logic [14:0] sig(input logic iord, mw, irw, pcen,
                                        input logic [1:0] pcsrc,
                                        input logic regdst, m2r, rw, srca,
                                        input logic [1:0] srcb,
                                        input logic [2:0] alu);
        return {iord, mw, irw, pcen, pcsrc, regdst, m2r, rw, srca, srcb, alu};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the falling edge, compare 1ns later.
    task automatic cyc(input string tag, input logic rst, rdy, zero,
                       input logic [5:0] op, fn, input logic [14:0] exp);
        i_rst       = rst;
        i_MemReady  = rdy;
        i_zero_flag = zero;
        i_Op        = op;
        i_Funct     = fn;
        #1;
        check(tag, obs, exp);
        @(negedge i_clk);
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic [14:0] E_IDLE, E_FRDY, E_FWAIT, E_DEC, E_MADR, E_MRD, E_MWB, E_MWR;
    logic [14:0] E_EXSUB, E_EXSLT, E_EXBAD, E_ALUWB, E_BR1, E_BR0, E_AEX, E_AWB, E_JMP;

    initial begin
        E_IDLE  = sig(0,0,0,0,2'b00,0,0,0,0,2'b00,3'b010);
        E_FRDY  = sig(0,0,1,1,2'b00,0,0,0,0,2'b01,3'b010);
        E_FWAIT = sig(0,0,0,0,2'b00,0,0,0,0,2'b01,3'b010);
        E_DEC   = sig(0,0,0,0,2'b00,0,0,0,0,2'b11,3'b010);
        E_MADR  = sig(0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010);
        E_MRD   = sig(1,0,0,0,2'b00,0,0,0,0,2'b00,3'b010);
        E_MWB   = sig(0,0,0,0,2'b00,0,1,1,0,2'b00,3'b010);
        E_MWR   = sig(1,1,0,0,2'b00,0,0,0,0,2'b00,3'b010);
        E_EXSUB = sig(0,0,0,0,2'b00,0,0,0,1,2'b00,3'b110);
        E_EXSLT = sig(0,0,0,0,2'b00,0,0,0,1,2'b00,3'b111);
        E_EXBAD = sig(0,0,0,0,2'b00,0,0,0,1,2'b00,3'b010);
        E_ALUWB = sig(0,0,0,0,2'b00,1,0,1,0,2'b00,3'b010);
        E_BR1   = sig(0,0,0,1,2'b01,0,0,0,1,2'b00,3'b110);
        E_BR0   = sig(0,0,0,0,2'b01,0,0,0,1,2'b00,3'b110);
        E_AEX   = sig(0,0,0,0,2'b00,0,0,0,1,2'b10,3'b010);
        E_AWB   = sig(0,0,0,0,2'b00,0,0,1,0,2'b00,3'b010);
        E_JMP   = sig(0,0,0,1,2'b10,0,0,0,0,2'b00,3'b010);

        @(negedge i_clk);
        cyc("rst_c0", 1, 1, 0, RT, 0, E_IDLE);
        cyc("rst_c1", 1, 1, 0, RT, 0, E_IDLE);

        // lw with two wait cycles in MEMREAD
        cyc("lw_fetch",  0, 1, 0, LW, 0, E_FRDY);
        cyc("lw_decode", 0, 1, 0, LW, 0, E_DEC);
        cyc("lw_madr",   0, 1, 0, LW, 0, E_MADR);
        cyc("lw_mrd_w0", 0, 0, 0, LW, 0, E_MRD);
        cyc("lw_mrd_w1", 0, 0, 0, LW, 0, E_MRD);
        cyc("lw_mrd_ok", 0, 1, 0, LW, 0, E_MRD);
        cyc("lw_memwb",  0, 1, 0, LW, 0, E_MWB);

        cyc("sub_fetch", 0, 1, 0, RT, 6'b100010, E_FRDY);
        cyc("sub_dec",   0, 1, 0, RT, 6'b100010, E_DEC);
        cyc("sub_exec",  0, 1, 0, RT, 6'b100010, E_EXSUB);
        cyc("sub_wb",    0, 1, 0, RT, 6'b100010, E_ALUWB);

        cyc("slt_fetch", 0, 1, 0, RT, 6'b101010, E_FRDY);
        cyc("slt_dec",   0, 1, 0, RT, 6'b101010, E_DEC);
        cyc("slt_exec",  0, 1, 0, RT, 6'b101010, E_EXSLT);
        cyc("slt_wb",    0, 1, 0, RT, 6'b101010, E_ALUWB);

        cyc("badfn_fetch", 0, 1, 0, RT, 6'b111111, E_FRDY);
        cyc("badfn_dec",   0, 1, 0, RT, 6'b111111, E_DEC);
        cyc("badfn_exec",  0, 1, 0, RT, 6'b111111, E_EXBAD);

        // beq taken, then not taken; each returns to FETCH after 3 cycles
        cyc("beq1_fetch", 0, 1, 0, BEQ, 0, E_FRDY);
        cyc("beq1_dec",   0, 1, 0, BEQ, 0, E_DEC);
        cyc("beq1_br",    0, 1, 1, BEQ, 0, E_BR1);
        cyc("beq0_fetch", 0, 1, 0, BEQ, 0, E_FRDY);
        cyc("beq0_dec",   0, 1, 0, BEQ, 0, E_DEC);
        cyc("beq0_br",    0, 1, 0, BEQ, 0, E_BR0);

        cyc("addi_fetch", 0, 1, 0, ADDI, 0, E_FRDY);
        cyc("addi_dec",   0, 1, 0, ADDI, 0, E_DEC);
        cyc("addi_exec",  0, 1, 0, ADDI, 0, E_AEX);
        cyc("addi_wb",    0, 1, 0, ADDI, 0, E_AWB);

        cyc("j_fetch", 0, 1, 0, JMP, 0, E_FRDY);
        cyc("j_dec",   0, 1, 0, JMP, 0, E_DEC);
        cyc("j_jump",  0, 1, 0, JMP, 0, E_JMP);

        // Unknown opcode falls back to FETCH; first fetch cycle also stalls
        cyc("bad_fetch", 0, 1, 0, BAD, 0, E_FRDY);
        cyc("bad_dec",   0, 1, 0, BAD, 0, E_DEC);
        cyc("bad_fwait", 0, 0, 0, BAD, 0, E_FWAIT);

        // sw interrupted by reset while the write is still waiting
        cyc("sw_fetch",  0, 1, 0, SW, 0, E_FRDY);
        cyc("sw_dec",    0, 1, 0, SW, 0, E_DEC);
        cyc("sw_madr",   0, 1, 0, SW, 0, E_MADR);
        cyc("sw_mwr_w",  0, 0, 0, SW, 0, E_MWR);
        cyc("sw_rst",    1, 0, 0, SW, 0, E_IDLE);
        cyc("sw_post",   0, 0, 0, SW, 0, E_FWAIT);

        // sw to completion
        cyc("sw2_fetch", 0, 1, 0, SW, 0, E_FRDY);
        cyc("sw2_dec",   0, 1, 0, SW, 0, E_DEC);
        cyc("sw2_madr",  0, 1, 0, SW, 0, E_MADR);
        cyc("sw2_mwr",   0, 1, 0, SW, 0, E_MWR);
        cyc("sw2_next",  0, 1, 0, SW, 0, E_FRDY);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the MIPS core. It sequences the shared ALU, memory port, instruction register, register file and PC through fetch, decode, execute, memory and writeback steps. It is a Moore FSM with a small combinational ALU decoder. It sits beside the datapath: it receives opcode, funct, the ALU zero flag and a memory-ready handshake, and drives every datapath enable and mux select.

## Interface
- No parameters.
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_Op  in  6  instruction[31:26] from the instruction register.
- i_Funct  in  6  instruction[5:0].
- i_zero_flag  in  1  ALU zero flag.
- i_MemReady  in  1  memory access completes this cycle.
- o_IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- o_MemWrite  out  1  memory write strobe.
- o_IRWrite  out  1  instruction register load.
- o_PCEn  out  1  PC load.
- o_PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- o_RegDst  out  1  destination register: 0 = rt, 1 = rd.
- o_MemtoReg  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- o_RegWrite  out  1  register file write.
- o_ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- o_ALUSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- o_ALUControl  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.

## Operation
- Default for every output in every state is 0, except o_ALUControl, which defaults to 010.
- FETCH: ALUSrcB=01, add.
  - IRWrite and PCEn = i_MemReady.
  - Move to DECODE when i_MemReady is high; otherwise stay in FETCH.
- DECODE: ALUSrcB=11, add (computes the branch target). Next state by i_Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEXEC.
  - 000010 (j) -> JUMP.
  - Any other opcode -> FETCH (executes as a nop).
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1. Hold until i_MemReady, then MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWRITE: IorD=1, MemWrite=1, held until i_MemReady, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl from i_Funct:
  - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - A supported funct moves to ALUWB. An unsupported funct moves to FETCH with no register write.
- ALUWB: RegDst=1, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, o_PCEn = i_zero_flag (combinational) -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
- ADDIWB: RegWrite=1 (RegDst=0, MemtoReg=0) -> FETCH.
- JUMP: PCSrc=10, PCEn=1 -> FETCH.

## Timing
- The state register updates on the rising edge of i_clk.
- Outputs are combinational from the state register. The exceptions are:
  - o_PCEn in BRANCH, which also depends on i_zero_flag;
  - o_IRWrite and o_PCEn in FETCH, which also depend on i_MemReady.
- Reset:
  - i_rst high at an edge puts the state in FETCH.
  - While i_rst is high, all outputs are forced to 0 (o_ALUControl = 010). This includes a reset asserted mid-instruction or mid-memory-wait; no write strobe is issued.
- Zero-wait cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Unsupported opcode 2; R-type with unsupported funct 3.
- Each low cycle of i_MemReady in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable across the wait.
- i_Op and i_Funct are sampled only in DECODE, EXECUTE and MEMADR. They are stable from the instruction register after FETCH.
- o_MemWrite and o_RegWrite are never high in the same cycle.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - funct constants;
  - ALUControl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT);
  - the state enum typedef.
- Sub-module mips_alu_decoder: combinational, i_Funct -> ALUControl plus a funct_valid flag. It is used in EXECUTE.

## Test plan
- Reset: hold i_rst high for 2 cycles with i_MemReady=1 -> all enables 0 during reset; FETCH outputs (PCEn=1, IRWrite=1, ALUSrcB=01) on the first cycle after release.
- lw, Op=100011, i_MemReady low for 2 cycles in MEMREAD -> state sequence FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB; one RegWrite pulse with MemtoReg=1 and RegDst=0; 7 cycles total.
- R-type:
  - Funct=100010 -> ALUControl=110 in EXECUTE, then RegWrite with RegDst=1.
  - Funct=101010 -> ALUControl=111.
  - Funct=111111 -> return to FETCH with no RegWrite.
- beq, Op=000100:
  - zero=1 -> PCEn=1 with PCSrc=01 in BRANCH.
  - zero=0 -> PCEn=0.
  - Both cases return to FETCH after 3 cycles.
- sw, Op=101011, then reset asserted during MEMWRITE while i_MemReady=0 -> MemWrite drops in the reset cycle; state is FETCH after the edge.
- j (000010) -> PCEn=1 with PCSrc=10 on cycle 3. Unknown Op=111111 -> DECODE then FETCH, with no enables after FETCH.
